// File: rtl/score_display_if.sv
// Game-state inputs and score/display outputs shared between the game core and
// the score display block.
interface score_display_if;
  logic        start;
  logic        playing;
  logic        game_win;
  logic        game_lose;
  logic [2:0]  enemy_hit;
  logic [15:0] score_bcd;
  logic [15:0] high_bcd;
  logic [7:0]  anode;
  logic [7:0]  cathode;

  modport master (
    output start, playing, game_win, game_lose, enemy_hit,
    input  score_bcd, high_bcd, anode, cathode
  );

  modport slave (
    input  start, playing, game_win, game_lose, enemy_hit,
    output score_bcd, high_bcd, anode, cathode
  );
endinterface

// File: rtl/score_display.sv
// BCD score / high-score keeper driving an 8-digit multiplexed seven-segment
// display: digits 0-3 show the score, digits 4-7 show the high score.
module score_display #(
  parameter logic [15:0] POINTS    = 16'h0010,
  parameter int          SCAN_MSB  = 19,
  parameter int          BLINK_BIT = 25
) (
  input logic             ClkPort,
  input logic             reset,
  score_display_if.slave  bus
);
  // Wide enough to hold both the digit select and the blink bit.
  localparam int CNT_W = ((SCAN_MSB > BLINK_BIT) ? SCAN_MSB : BLINK_BIT) + 1;

  logic [15:0]      score_reg, score_next;
  logic [15:0]      high_reg, high_next;
  logic [2:0]       hit_d_reg;
  logic             end_d_reg;
  logic [CNT_W-1:0] cnt_reg;

  logic [2:0]  hit_edge;
  logic [1:0]  hit_count;
  logic        end_now;
  logic [15:0] add1, add2, add3;

  // Digit-wise decimal add; a carry out of the top digit saturates to 9999.
  function automatic logic [15:0] bcd_add(input logic [15:0] a, input logic [15:0] b);
    logic [15:0] sum;
    logic        carry;
    logic [4:0]  d;
    sum   = '0;
    carry = 1'b0;
    for (int i = 0; i < 4; i++) begin
      d = {1'b0, a[4*i +: 4]} + {1'b0, b[4*i +: 4]} + {4'b0, carry};
      if (d > 5'd9) begin
        d     = d - 5'd10;
        carry = 1'b1;
      end else begin
        carry = 1'b0;
      end
      sum[4*i +: 4] = d[3:0];
    end
    if (carry) sum = 16'h9999;
    return sum;
  endfunction

  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_hit_edge
      assign hit_edge[gi] = bus.enemy_hit[gi] & ~hit_d_reg[gi];
    end
  endgenerate

  assign hit_count = {1'b0, hit_edge[0]} + {1'b0, hit_edge[1]} + {1'b0, hit_edge[2]};
  assign end_now   = bus.game_win | bus.game_lose;

  // Chained adders give 1, 2 or 3 kills' worth; saturation propagates down the chain.
  assign add1 = bcd_add(score_reg, POINTS);
  assign add2 = bcd_add(add1, POINTS);
  assign add3 = bcd_add(add2, POINTS);

  always_comb begin
    score_next = score_reg;
    if (bus.start) begin
      score_next = '0;
    end else if (bus.playing) begin
      case (hit_count)
        2'd1:    score_next = add1;
        2'd2:    score_next = add2;
        2'd3:    score_next = add3;
        default: score_next = score_reg;
      endcase
    end
  end

  // Valid BCD orders the same as plain binary, so a magnitude compare suffices.
  always_comb begin
    high_next = high_reg;
    if (end_now && !end_d_reg && (score_reg > high_reg)) begin
      high_next = score_reg;
    end
  end

  always_ff @(posedge ClkPort or posedge reset) begin
    if (reset) begin
      score_reg <= '0;
      high_reg  <= '0;
      hit_d_reg <= '0;
      end_d_reg <= 1'b0;
      cnt_reg   <= '0;
    end else begin
      score_reg <= score_next;
      high_reg  <= high_next;
      hit_d_reg <= bus.enemy_hit;
      end_d_reg <= end_now;
      cnt_reg   <= cnt_reg + 1'b1;
    end
  end

  assign bus.score_bcd = score_reg;
  assign bus.high_bcd  = high_reg;

  logic [2:0] sel;
  logic [1:0] digit_idx;
  logic [3:0] score_blank, high_blank;
  logic [3:0] digit_val;
  logic       digit_blank;
  logic [6:0] seg_val;
  logic [7:0] cathode_val;

  assign sel       = cnt_reg[SCAN_MSB -: 3];
  assign digit_idx = sel[1:0];

  // Digit k is a leading zero when it and everything above it in its group is zero.
  assign score_blank[0] = 1'b0;
  assign high_blank[0]  = 1'b0;
  generate
    for (genvar gi = 1; gi < 4; gi++) begin : g_blank
      assign score_blank[gi] = (score_reg[15:4*gi] == '0);
      assign high_blank[gi]  = (high_reg[15:4*gi] == '0);
    end
  endgenerate

  assign digit_val   = sel[2] ? high_reg[4*digit_idx +: 4] : score_reg[4*digit_idx +: 4];
  assign digit_blank = sel[2] ? high_blank[digit_idx] : score_blank[digit_idx];

  always_comb begin
    case (digit_val)
      4'd0:    seg_val = 7'b0000001;
      4'd1:    seg_val = 7'b1001111;
      4'd2:    seg_val = 7'b0010010;
      4'd3:    seg_val = 7'b0000110;
      4'd4:    seg_val = 7'b1001100;
      4'd5:    seg_val = 7'b0100100;
      4'd6:    seg_val = 7'b0100000;
      4'd7:    seg_val = 7'b0001111;
      4'd8:    seg_val = 7'b0000000;
      4'd9:    seg_val = 7'b0000100;
      default: seg_val = 7'h7F;
    endcase
  end

  always_comb begin
    cathode_val = {(digit_blank ? 7'h7F : seg_val), ~bus.game_win};
    if (bus.game_lose && cnt_reg[BLINK_BIT] && !sel[2]) begin
      cathode_val = 8'hFF;
    end
  end

  assign bus.anode   = ~(8'b1 << sel);
  assign bus.cathode = cathode_val;
endmodule

// File: tb/tb_score_display.sv
// Randomised scoreboard bench for score_display; scan/blink bits are shrunk so
// whole scan and blink periods fit in a short run.
module tb_score_display;
  localparam int SCAN_MSB   = 4;
  localparam int BLINK_BIT  = 7;
  localparam int POINTS_DEC = 10;
  localparam logic [6:0] SEG [10] = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
                                      7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
                                      7'b0000000, 7'b0000100};

  logic ClkPort = 1'b0;
  logic reset;
  score_display_if bus();

  score_display #(.POINTS(16'h0010), .SCAN_MSB(SCAN_MSB), .BLINK_BIT(BLINK_BIT)) dut (
    .ClkPort(ClkPort),
    .reset  (reset),
    .bus    (bus)
  );

  always #5 ClkPort = ~ClkPort;

  typedef struct {
    logic [15:0] score;
    logic [15:0] high;
    logic [7:0]  an;
    logic [7:0]  ca;
  } exp_t;

  exp_t q[$];
  int n_vec = 0;
  int n_err = 0;

  // Reference state: plain decimal integers and a cycle count.
  int       m_score, m_high, m_cnt;
  logic [2:0] m_hit_d;
  logic       m_end_d;

  function automatic logic [15:0] to_bcd(int v);
    return {4'(v / 1000 % 10), 4'(v / 100 % 10), 4'(v / 10 % 10), 4'(v % 10)};
  endfunction

  function automatic logic [7:0] exp_anode(int cnt);
    int sel;
    sel = (cnt >> (SCAN_MSB - 2)) & 7;
    return ~(8'd1 << sel);
  endfunction

  function automatic logic [7:0] exp_cathode(int sc, int hi, int cnt, logic w, logic l);
    int sel, val, k, p10;
    logic [6:0] seg;
    sel = (cnt >> (SCAN_MSB - 2)) & 7;
    val = (sel < 4) ? sc : hi;
    k   = sel % 4;
    p10 = (k == 0) ? 1 : (k == 1) ? 10 : (k == 2) ? 100 : 1000;
    if (l && (((cnt >> BLINK_BIT) & 1) == 1) && sel < 4) return 8'hFF;
    if (k > 0 && val < p10) seg = 7'h7F;
    else                    seg = SEG[(val / p10) % 10];
    return {seg, ~w};
  endfunction

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, req, $time);
    end
  endtask

  // Called at a negedge: drive inputs, advance the model, queue the expectation.
  task automatic step(input logic s, input logic p, input logic w, input logic l,
                      input logic [2:0] h);
    exp_t e;
    int   n;
    bus.start = s; bus.playing = p; bus.game_win = w; bus.game_lose = l; bus.enemy_hit = h;
    n = $countones(h & ~m_hit_d);
    if ((w | l) && !m_end_d && m_score > m_high) m_high = m_score;
    if (s) m_score = 0;
    else if (p && n > 0) m_score = (m_score + n * POINTS_DEC > 9999) ? 9999 : m_score + n * POINTS_DEC;
    m_hit_d = h;
    m_end_d = w | l;
    m_cnt++;
    e.score = to_bcd(m_score);
    e.high  = to_bcd(m_high);
    e.an    = exp_anode(m_cnt);
    e.ca    = exp_cathode(m_score, m_high, m_cnt, w, l);
    q.push_back(e);
    @(negedge ClkPort);
  endtask

  task automatic model_reset();
    m_score = 0; m_high = 0; m_cnt = 0; m_hit_d = '0; m_end_d = 1'b0;
  endtask

  task automatic check_reset_now();
    chk("rst_score", bus.score_bcd, 16'h0000);
    chk("rst_high", bus.high_bcd, 16'h0000);
    chk("rst_anode", {8'h00, bus.anode}, 16'h00FE);
    chk("rst_cathode", {8'h00, bus.cathode},
        {8'h00, exp_cathode(0, 0, 0, bus.game_win, bus.game_lose)});
  endtask

  always @(posedge ClkPort) begin
    exp_t e;
    #1;
    if (q.size() > 0) begin
      e = q.pop_front();
      chk("score_bcd", bus.score_bcd, e.score);
      chk("high_bcd", bus.high_bcd, e.high);
      chk("anode", {8'h00, bus.anode}, {8'h00, e.an});
      chk("cathode", {8'h00, bus.cathode}, {8'h00, e.ca});
    end
  end

  initial begin
    logic [2:0] h;
    int         len;
    logic       w;
    reset = 1'b1;
    bus.start = 1'b0; bus.playing = 1'b0; bus.game_win = 1'b0; bus.game_lose = 1'b0;
    bus.enemy_hit = '0;
    model_reset();
    #1;
    check_reset_now();
    repeat (3) @(negedge ClkPort);
    reset = 1'b0;

    // Idle over more than one full scan.
    repeat (40) step(0, 1, 0, 0, 3'b000);

    // Single hits, held levels, then all three at once.
    step(0, 1, 0, 0, 3'b001);
    repeat (9) step(0, 1, 0, 0, 3'b001);
    repeat (5) step(0, 1, 0, 0, 3'b011);
    step(0, 1, 0, 0, 3'b000);
    step(0, 1, 0, 0, 3'b111);
    step(0, 1, 0, 0, 3'b000);

    // Carry 0090 -> 0100.
    step(1, 0, 0, 0, 3'b000);
    for (int i = 0; i < 10; i++) begin
      step(0, 1, 0, 0, 3'b001);
      step(0, 1, 0, 0, 3'b000);
    end
    repeat (40) step(0, 1, 0, 0, 3'b000);

    // Random games ending alternately in win and lose.
    h = '0;
    for (int g = 0; g < 6; g++) begin
      repeat (3) step(1, 0, 0, 0, h);
      len = $urandom_range(40, 150);
      for (int i = 0; i < len; i++) begin
        for (int b = 0; b < 3; b++) if ($urandom_range(0, 2) == 0) h[b] = ~h[b];
        step(($urandom_range(0, 63) == 0), ($urandom_range(0, 15) != 0), 0, 0, h);
      end
      w = g[0];
      for (int i = 0; i < 300; i++) begin
        for (int b = 0; b < 3; b++) if ($urandom_range(0, 3) == 0) h[b] = ~h[b];
        step(0, 0, w, ~w, h);
      end
    end

    // Saturation at 9999, then a losing end to capture it as the high score.
    step(1, 0, 0, 0, 3'b000);
    for (int i = 0; i < 340; i++) begin
      step(0, 1, 0, 0, 3'b111);
      step(0, 1, 0, 0, 3'b000);
    end
    step(0, 1, 0, 0, 3'b001);
    step(0, 1, 0, 0, 3'b000);
    repeat (20) step(0, 0, 0, 1, 3'b000);

    // Asynchronous reset mid-run, checked before any clock edge.
    step(0, 1, 0, 0, 3'b000);
    #2;
    reset = 1'b1;
    model_reset();
    #1;
    check_reset_now();
    @(negedge ClkPort);
    @(negedge ClkPort);
    reset = 1'b0;
    repeat (40) step(0, 1, 0, 0, 3'b000);

    @(posedge ClkPort);
    #3;
    if (q.size() != 0) begin
      n_err++;
      $display("FAIL queue_drain: %0d entries left, expected 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
